// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: op codes, default sizing and loader states.
package matrix_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_DIM_DEF   = 5;
  localparam int NUM_SLOTS_DEF = 10;
  localparam int ADDR_W_DEF    = 8;
  localparam int MAX_ELEMS     = MAX_DIM_DEF * MAX_DIM_DEF;

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALAR    = 3'b010;
  localparam logic [2:0] OP_MULTIPLY  = 3'b011;
  localparam logic [2:0] OP_CONV      = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_READ_A = 3'd2,
    ST_READ_B = 3'd3,
    ST_DRAIN  = 3'd4
  } loader_state_e;

  function automatic logic op_uses_b(input logic [2:0] op);
    case (op)
      OP_ADD, OP_MULTIPLY, OP_CONV: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic dim_valid(input logic [2:0] d, input int max_dim);
    return (d != 3'd0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/operand_addr_gen.sv
// Flat RAM address for element idx of slot id, with a slot/element range check.
module operand_addr_gen
  import matrix_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ID_W      = 4,
  parameter int IDX_W     = 5,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int ELEMS     = MAX_ELEMS
) (
  input  logic [ID_W-1:0]   id,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  always_comb begin
    addr     = ADDR_W'(int'(id) * ELEMS + int'(idx));
    in_range = (int'(id) < NUM_SLOTS) && (int'(idx) < ELEMS);
  end

endmodule

// File: rtl/operand_loader.sv
// Fetches operand matrices from the element RAM into flat row-major buffers.
// Optional OPERAND_ZERO_PAD_EN clears the target buffers before each load.
module operand_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_DIM   = MAX_DIM_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [2:0]                          op_type,
  input  logic [3:0]                          id_a,
  input  logic [3:0]                          id_b,
  input  logic [2:0]                          a_m,
  input  logic [2:0]                          a_n,
  input  logic [2:0]                          b_m,
  input  logic [2:0]                          b_n,
  output logic                                mem_rd_en,
  output logic [ADDR_W-1:0]                   mem_rd_addr,
  input  logic [DATA_W-1:0]                   mem_rd_data,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   buf_a,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   buf_b,
  output logic [2:0]                          out_a_m,
  output logic [2:0]                          out_a_n,
  output logic [2:0]                          out_b_m,
  output logic [2:0]                          out_b_n,
  output logic                                busy,
  output logic                                load_done,
  output logic                                load_error
);

  localparam int ELEMS = MAX_DIM * MAX_DIM;
  localparam int CNT_W = $clog2(ELEMS + 1);
  localparam int BUF_W = ELEMS * DATA_W;

  loader_state_e     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        id_a_q, id_a_d, id_b_q, id_b_d;
  logic [2:0]        a_m_q, a_m_d, a_n_q, a_n_d, b_m_q, b_m_d, b_n_q, b_n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tag_valid_q, tag_valid_d, tag_sel_q, tag_sel_d;
  logic [CNT_W-1:0]  tag_idx_q, tag_idx_d;
  logic [BUF_W-1:0]  buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CNT_W-1:0]  na_s, nb_s;
  logic              use_b_s, cfg_bad_s;
  logic [3:0]        gen_id_s;
  logic [ADDR_W-1:0] addr_s;
  logic              addr_ok_s;

  // Operation sizes and configuration check from the latched request.
  always_comb begin
    use_b_s = op_uses_b(op_q);
    na_s    = CNT_W'(int'(a_m_q) * int'(a_n_q));
    if (use_b_s) begin
      nb_s = CNT_W'(int'(b_m_q) * int'(b_n_q));
    end else begin
      nb_s = '0;
    end
    cfg_bad_s = (int'(id_a_q) >= NUM_SLOTS) || !dim_valid(a_m_q, MAX_DIM) ||
                !dim_valid(a_n_q, MAX_DIM) ||
                (use_b_s && ((int'(id_b_q) >= NUM_SLOTS) || !dim_valid(b_m_q, MAX_DIM) ||
                             !dim_valid(b_n_q, MAX_DIM)));
  end

  // Next-state, capture pipeline and buffer update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_a_d      = id_a_q;
    id_b_d      = id_b_q;
    a_m_d       = a_m_q;
    a_n_d       = a_n_q;
    b_m_d       = b_m_q;
    b_n_d       = b_n_q;
    idx_d       = idx_q;
    err_d       = err_q;
    done_d      = 1'b0;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    tag_valid_d = rd_en_q;
    tag_sel_d   = (state_q == ST_READ_B);
    tag_idx_d   = idx_q;

    // The tag trails its read by one cycle, lining up with the RAM data.
    if (tag_valid_q) begin
      if (tag_sel_q) begin
        buf_b_d[int'(tag_idx_q)*DATA_W +: DATA_W] = mem_rd_data;
      end else begin
        buf_a_d[int'(tag_idx_q)*DATA_W +: DATA_W] = mem_rd_data;
      end
    end else begin
      buf_a_d = buf_a_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_type;
          id_a_d = id_a;
          a_m_d  = a_m;
          a_n_d  = a_n;
          if (op_uses_b(op_type)) begin
            id_b_d = id_b;
            b_m_d  = b_m;
            b_n_d  = b_n;
          end else begin
            id_b_d = id_b_q;
          end
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (cfg_bad_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d   = '0;
          state_d = ST_READ_A;
`ifdef OPERAND_ZERO_PAD_EN
          buf_a_d = '0;
          if (nb_s != '0) begin
            buf_b_d = '0;
          end else begin
            buf_b_d = buf_b_q;
          end
`endif
        end
      end
      ST_READ_A: begin
        if (idx_q == na_s - CNT_W'(1)) begin
          idx_d = '0;
          if (nb_s != '0) begin
            state_d = ST_READ_B;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      ST_READ_B: begin
        if (idx_q == nb_s - CNT_W'(1)) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  operand_addr_gen #(
    .ADDR_W   (ADDR_W),
    .ID_W     (4),
    .IDX_W    (CNT_W),
    .NUM_SLOTS(NUM_SLOTS),
    .ELEMS    (ELEMS)
  ) u_addr_gen (
    .id      (gen_id_s),
    .idx     (idx_d),
    .addr    (addr_s),
    .in_range(addr_ok_s)
  );

  // Read strobe and address are registered from the next-state view.
  always_comb begin
    if (state_d == ST_READ_B) begin
      gen_id_s = id_b_d;
    end else begin
      gen_id_s = id_a_d;
    end
    rd_en_d = ((state_d == ST_READ_A) || (state_d == ST_READ_B)) && addr_ok_s;
    if (rd_en_d) begin
      rd_addr_d = addr_s;
    end else begin
      rd_addr_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      id_a_q      <= 4'd0;
      id_b_q      <= 4'd0;
      a_m_q       <= 3'd0;
      a_n_q       <= 3'd0;
      b_m_q       <= 3'd0;
      b_n_q       <= 3'd0;
      idx_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tag_valid_q <= 1'b0;
      tag_sel_q   <= 1'b0;
      tag_idx_q   <= '0;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_a_q      <= id_a_d;
      id_b_q      <= id_b_d;
      a_m_q       <= a_m_d;
      a_n_q       <= a_n_d;
      b_m_q       <= b_m_d;
      b_n_q       <= b_n_d;
      idx_q       <= idx_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tag_valid_q <= tag_valid_d;
      tag_sel_q   <= tag_sel_d;
      tag_idx_q   <= tag_idx_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign buf_a       = buf_a_q;
  assign buf_b       = buf_b_q;
  assign out_a_m     = a_m_q;
  assign out_a_n     = a_n_q;
  assign out_b_m     = b_m_q;
  assign out_b_n     = b_n_q;
  assign busy        = busy_q;
  assign load_done   = done_q;
  assign load_error  = err_q;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Downstream stage of the operand-selection FSM: consumes selected_a/selected_b on select_done and fetches both matrices' elements from the shared matrix element RAM.
- Unpacks the elements into flat, row-major operand buffers for the compute units (transpose/add/scalar/multiply/conv), then pulses load_done.
- Single-operand ops (transpose, scalar) fetch A only.

Parameters:
- DATA_W, 8, element width in bits
- MAX_DIM, 5, maximum rows/columns per matrix
- NUM_SLOTS, 10, matrix slots in RAM
- ADDR_W, 8, RAM address width; must satisfy NUM_SLOTS*MAX_DIM*MAX_DIM <= 2^ADDR_W

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  load request; driven by select_done of the selector
- op_type  in  3  000 transpose, 001 add, 010 scalar, 011 multiply, 100 conv
- id_a, id_b  in  4  slot ids
- a_m, a_n, b_m, b_n  in  3  dimensions of slots id_a/id_b from the metadata table
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  ADDR_W  = id*MAX_DIM*MAX_DIM + element index
- mem_rd_data  in  DATA_W  synchronous RAM data, valid 1 cycle after mem_rd_en
- buf_a, buf_b  out  MAX_DIM*MAX_DIM*DATA_W  element i occupies [i*DATA_W +: DATA_W]
- out_a_m, out_a_n, out_b_m, out_b_n  out  3  latched dimensions
- busy  out  1  high from the CHECK state until load_done
- load_done  out  1  one-cycle pulse
- load_error  out  1  sticky error flag

Behaviour:
- Reset: all outputs, buffers, counters and the capture pipeline go to 0; state goes to IDLE. Reset mid-burst aborts with no done pulse.
- Operation sizes: NA = a_m*a_n. NB = b_m*b_n for op_type 001/011/100, else 0. All values are 5-bit products, max 25.
- States and transitions:
  - IDLE: start=1 → latch op_type, ids and dims; clear load_error; go to CHECK. start while busy is ignored.
  - CHECK (1 cycle): if any used id >= NUM_SLOTS, or any used dim is 0 or > MAX_DIM → set load_error, go to IDLE, issue no reads. Otherwise set idx=0 and go to READ_A.
  - READ_A: issue one read per cycle for idx 0..NA-1. After the last issue → READ_B if NB>0, else DRAIN.
  - READ_B: same as READ_A for B, idx 0..NB-1, then DRAIN.
  - DRAIN (1 cycle): capture the final returning word, then go to IDLE and pulse load_done.
- Capture pipeline: a registered {valid, sel_b, idx} tag follows each issue by one cycle. The returned word is written to buf_a[idx] or buf_b[idx] per the tag. The A→B boundary has no bubble: the last A capture overlaps the first B issue.
- Latency: load_done rises at the (NA+NB+2)th rising edge after the edge that sampled start. busy falls on that same edge.
- mem_rd_en is high exactly NA+NB cycles per load and never during CHECK or DRAIN.
- Buffer entries at index >= NA (resp. NB) keep their previous value (see the optional feature).
- For single-operand ops, buf_b and out_b_* are unchanged.
- load_error is cleared only by an accepted start or by reset.

Optional Feature:
- Macro: OPERAND_ZERO_PAD_EN.
- Defined: in CHECK, when no error is found, buf_a (and buf_b if NB>0) are fully cleared to 0 before the reads, so unused entries read 0. Latency is unchanged.
- Undefined: unused entries are stale.

Decomposition:
- Shared package matrix_pkg holds: op_type codes, DATA_W/MAX_DIM/NUM_SLOTS defaults, the MAX_ELEMS = MAX_DIM*MAX_DIM constant, and the loader state enum.
- One sub-module, operand_addr_gen: combinational id*MAX_ELEMS + idx with a range check. The range check is also reused by the result writeback stage.

Test Plan:
- Multiply, A=slot 2 (2x3), B=slot 7 (3x2), RAM preloaded with value=address → reads 50..55 then 175..180; buf_a[0..5]=50..55, buf_b[0..5]=175..180; load_done at edge 14; exactly 12 mem_rd_en cycles.
- Transpose, slot 9 (3x3) → 9 reads at 225..233; done at edge 11; buf_b unchanged.
- id_a=12, or a_m=0, or b_n=6 for an add → load_error=1, no mem_rd_en, no load_done, busy high for 1 cycle only; next valid start clears load_error.
- start re-asserted during READ_A → ignored; the original load completes with unchanged timing.
- rst asserted mid READ_B → all outputs 0 immediately, no load_done; a fresh start afterwards completes correctly.
- With OPERAND_ZERO_PAD_EN: load 5x5, then 1x1 of value 0x3C → buf_a[0]=0x3C, buf_a[1..24]=0. Without the macro, entries 1..24 retain the 5x5 data.
